// File: rtl/up_down_count_pkg.sv
// Shared constants for the up/down counter: direction encodings and default width.
package up_down_count_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Count direction encoding on the mode input
  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

endpackage : up_down_count_pkg

// File: rtl/up_down_count_if.sv
// Control/data bundle for the up/down counter.
//   data : parallel load value
//   load : synchronous load request (1 = load)
//   mode : count direction (MODE_UP / MODE_DOWN)
//   q    : registered counter value
// master drives data/load/mode and observes q; slave is the counter side.
interface up_down_count_if
  import up_down_count_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data;
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] q;

  modport master (
    output data,
    output load,
    output mode,
    input  q
  );

  modport slave (
    input  data,
    input  load,
    input  mode,
    output q
  );

endinterface : up_down_count_if

// File: rtl/up_down_count.sv
// Loadable WIDTH-bit up/down counter with asynchronous active-low reset.
// Ports (positional order kept for legacy instantiations):
//   data : parallel load value
//   clk  : clock, all state changes on rising edge except reset
//   rst  : asynchronous reset, active low, forces q to 0
//   load : synchronous load, takes priority over counting
//   mode : direction, MODE_UP counts up, MODE_DOWN counts down
//   q    : registered count, wraps modulo 2^WIDTH in both directions
module up_down_count
  import up_down_count_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count_next;

  // Next-count selection: load wins, otherwise step in the requested direction
  always_comb begin
    count_next = q;
    if (load) begin
      count_next = data;
    end else if (mode == MODE_UP) begin
      count_next = q + WIDTH'(1);
    end else begin
      count_next = q - WIDTH'(1);
    end
  end

  // Count register; reset wins over any pending load or count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      q <= count_next;
    end
  end

endmodule : up_down_count

// File: tb/tb_up_down_count.sv
// Directed self-checking bench for up_down_count (WIDTH = 4).
module tb_up_down_count;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  up_down_count_if #(.WIDTH(W)) bus ();

  up_down_count #(.WIDTH(W)) dut (
    .data (bus.data),
    .clk  (clk),
    .rst  (rst),
    .load (bus.load),
    .mode (bus.mode),
    .q    (bus.q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.mode = 1'b1;
    bus.data = 4'b0000;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.q !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_initial: q=%b expected %b", bus.q, 4'b0000);
    end
    // Make q nonzero, then drop reset between edges
    tick();
    rst      = 1'b1;
    bus.load = 1'b1;
    bus.data = 4'b1010;
    tick();
    n_checks++;
    if (bus.q !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_preload: q=%b expected %b", bus.q, 4'b1010);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.q !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: q=%b expected %b", bus.q, 4'b0000);
    end
    // Held in reset: load, mode and data ignored
    bus.data = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      bus.mode = i[0];
      tick();
      n_checks++;
      if (bus.q !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: q=%b expected %b", i, bus.q, 4'b0000);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_load();
    bus.load = 1'b1;
    bus.mode = 1'b1;
    bus.data = 4'b0011;
    tick();
    n_checks++;
    if (bus.q !== 4'b0011) begin
      n_fail++;
      $display("FAIL load_up_mode: q=%b expected %b", bus.q, 4'b0011);
    end
    bus.mode = 1'b0;
    bus.data = 4'b1000;
    tick();
    n_checks++;
    if (bus.q !== 4'b1000) begin
      n_fail++;
      $display("FAIL load_down_mode: q=%b expected %b", bus.q, 4'b1000);
    end
  endtask

  task automatic test_down_count();
    logic [3:0] exp_down [3];
    exp_down = '{4'b0111, 4'b0110, 4'b0101};
    bus.load = 1'b0;
    bus.mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data = 4'(4'hc + i);  // data must be ignored while load=0
      tick();
      n_checks++;
      if (bus.q !== exp_down[i]) begin
        n_fail++;
        $display("FAIL down_count[%0d]: q=%b expected %b", i, bus.q, exp_down[i]);
      end
    end
  endtask

  task automatic test_up_count();
    logic [3:0] exp_up [3];
    exp_up = '{4'b0100, 4'b0101, 4'b0110};
    bus.load = 1'b1;
    bus.mode = 1'b1;
    bus.data = 4'b0011;
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data = 4'b1001;
      tick();
      n_checks++;
      if (bus.q !== exp_up[i]) begin
        n_fail++;
        $display("FAIL up_count[%0d]: q=%b expected %b", i, bus.q, exp_up[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bus.load = 1'b1;
    bus.data = 4'b0000;
    tick();
    bus.load = 1'b0;
    bus.mode = 1'b0;
    tick();
    n_checks++;
    if (bus.q !== 4'b1111) begin
      n_fail++;
      $display("FAIL wrap_down: q=%b expected %b", bus.q, 4'b1111);
    end
    // Mode change takes effect from the current value
    bus.mode = 1'b1;
    tick();
    n_checks++;
    if (bus.q !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_up: q=%b expected %b", bus.q, 4'b0000);
    end
    tick();
    n_checks++;
    if (bus.q !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_up_next: q=%b expected %b", bus.q, 4'b0001);
    end
  endtask

  task automatic test_priority();
    logic [3:0] vec [4];
    vec = '{4'b0101, 4'b1110, 4'b0001, 4'b1111};
    bus.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mode = i[0];
      bus.data = vec[i];
      tick();
      n_checks++;
      if (bus.q !== vec[i]) begin
        n_fail++;
        $display("FAIL load_priority[%0d]: q=%b expected %b", i, bus.q, vec[i]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    bus.load = 1'b1;
    bus.mode = 1'b1;
    bus.data = 4'b0101;
    tick();
    bus.load = 1'b0;
    tick();
    n_checks++;
    if (bus.q !== 4'b0110) begin
      n_fail++;
      $display("FAIL mid_count_pre: q=%b expected %b", bus.q, 4'b0110);
    end
    // Reset between edges, coincident with a pending load
    bus.load = 1'b1;
    bus.data = 4'b1100;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.q !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_count_async: q=%b expected %b", bus.q, 4'b0000);
    end
    tick();
    n_checks++;
    if (bus.q !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_beats_load: q=%b expected %b", bus.q, 4'b0000);
    end
    bus.load = 1'b0;
    #2 rst = 1'b1;
    tick();
    n_checks++;
    if (bus.q !== 4'b0001) begin
      n_fail++;
      $display("FAIL restart_1: q=%b expected %b", bus.q, 4'b0001);
    end
    tick();
    n_checks++;
    if (bus.q !== 4'b0010) begin
      n_fail++;
      $display("FAIL restart_2: q=%b expected %b", bus.q, 4'b0010);
    end
  endtask

  task automatic test_back_to_back_mode();
    // 0010 -> down 0001 -> up 0010 -> down 0001 -> down 0000 -> down 1111
    logic [3:0] exp_seq [5];
    logic       mode_seq [5];
    exp_seq  = '{4'b0001, 4'b0010, 4'b0001, 4'b0000, 4'b1111};
    mode_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.mode = mode_seq[i];
      tick();
      n_checks++;
      if (bus.q !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL mode_toggle[%0d]: q=%b expected %b", i, bus.q, exp_seq[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_load();
    test_down_count();
    test_up_count();
    test_wrap();
    test_priority();
    test_reset_mid_count();
    test_back_to_back_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_up_down_count

// File: doc/up_down_count.md
UP_DOWN_COUNT -- requirements
Module: up_down_count

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and data width in bits; the 4-bit bench uses the default.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge except reset.
REQ-003 SHALL have port rst, input, 1 bit, reset; asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port data, input, WIDTH bits, parallel load value.
REQ-005 SHALL have port load, input, 1 bit, synchronous parallel-load request; 1 = load.
REQ-006 SHALL have port mode, input, 1 bit, count direction; 1 = up, 0 = down.
REQ-007 SHALL have port q, output, WIDTH bits, registered counter value.
REQ-008 SHALL declare ports in positional order data, clk, rst, load, mode, q, so existing positional instantiations bind correctly.

Function
REQ-009 SHALL hold a single WIDTH-bit count register driven directly onto q; q is not combinationally derived from inputs.
REQ-010 SHALL, on a rising clk edge with rst=1 and load=1, set q to data, regardless of mode (load priority over counting).
REQ-011 SHALL, on a rising clk edge with rst=1, load=0 and mode=1, set q to q+1 modulo 2^WIDTH.
REQ-012 SHALL, on a rising clk edge with rst=1, load=0 and mode=0, set q to q-1 modulo 2^WIDTH.
REQ-013 SHALL count continuously while enabled by rst=1; there is no hold state and no separate enable.
REQ-014 SHALL wrap up-count from 2^WIDTH-1 to 0 (4'b1111 -> 4'b0000) with no flag or stall.
REQ-015 SHALL wrap down-count from 0 to 2^WIDTH-1 (4'b0000 -> 4'b1111) with no flag or stall.
REQ-016 SHALL have one-cycle latency: a load, mode or data change sampled at edge N is reflected in q after edge N.
REQ-017 SHALL sample data only when load=1; data changes while load=0 have no effect.
REQ-018 SHALL treat a mode change as taking effect at the next rising edge, from the current q value.

Reset
REQ-019 SHALL force q to 0 immediately when rst falls, without waiting for clk.
REQ-020 SHALL hold q at 0 while rst=0, ignoring load, mode and data.
REQ-021 SHALL resume operation at the first rising clk edge after rst returns to 1, evaluated per REQ-010 to REQ-012.
REQ-022 SHALL, on reset mid-count or coincident with a load, discard the pending operation; reset wins.

Structure
REQ-023 SHALL place the direction constants MODE_UP=1 and MODE_DOWN=0 and the default width constant in the shared package.
REQ-024 SHALL be implemented as one flat module with one sequential process; no sub-module is required.
REQ-025 SHALL compute the next-count selection (load / up / down) in a separate combinational block feeding the register.

Verification
REQ-026 SHALL check reset: drive rst=0 with q nonzero -> q=0000 before the next clk edge; q stays 0000 while rst=0.
REQ-027 SHALL check load: rst=1, load=1, mode=1, data=0011 -> q=0011 after one edge; data=1000 with mode=0 -> q=1000.
REQ-028 SHALL check up-count: from q=0011 with load=0, mode=1 -> q=0100, 0101, 0110 on successive edges.
REQ-029 SHALL check down-count and wrap: from q=1000 with load=0, mode=0 -> 0111, 0110, and so on; from 0000 down -> 1111; from 1111 up -> 0000.
REQ-030 SHALL check priority and asynchronous reset: load=1 with mode toggling -> q=data; assert rst=0 between clk edges during counting -> q=0000 immediately, then counting restarts from 0 after release.
